// File: rtl/prbs31_pkg.sv
// PRBS31 shared definitions: polynomial taps, checker state type, next-bit predictor.
// Latency: n/a (package of constants, types and a pure combinational function).
// Backpressure: n/a.
package prbs31_pkg;

    localparam int PRBS_LEN = 31;
    localparam int TAP_A    = 27;
    localparam int TAP_B    = 30;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // h[0] holds the most recent bit; the next bit of x^31 + x^28 + 1 is h[27] ^ h[30].
    function automatic logic prbs31_next(input logic [PRBS_LEN-1:0] h);
        return h[TAP_A] ^ h[TAP_B];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count reflects inc/clr one cycle after they are sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports: clk, rst_n (synchronous, active-high), inc, clr, count[WIDTH-1:0].
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 receive checker with error counting and loss-of-lock.
// Latency: one cycle from a sampled bit to err_pulse / locked.
// Backpressure: none; din_valid=0 cycles leave all state untouched.
//
// Ports: clk; rst_n (synchronous, active-high); din/din_valid serial input;
//        clr_cnt clears counters; locked, err_pulse, err_count, bit_count status.
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int   LOCK_CNT    = 64,
    parameter int   WINDOW      = 64,
    parameter int   UNLOCK_ERRS = 8,
    parameter int   COUNT_W     = 16,
    parameter logic INVERT      = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               din_valid,
    input  logic               clr_cnt,
    output logic               locked,
    output logic               err_pulse,
    output logic [COUNT_W-1:0] err_count,
    output logic [COUNT_W-1:0] bit_count
);

    localparam int FW = $clog2(PRBS_LEN + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WINDOW + 1);

    localparam logic [FW-1:0] FILL_FULL = FW'(PRBS_LEN);
    localparam logic [MW-1:0] MATCH_TGT = MW'(LOCK_CNT);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [WW-1:0] ERR_TGT   = WW'(UNLOCK_ERRS);

    state_t              state_q, state_d;
    logic [PRBS_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [MW-1:0]       match_q, match_d;
    logic [WW-1:0]       win_bit_q, win_bit_d;
    logic [WW-1:0]       win_err_q, win_err_d;
    logic [WW-1:0]       win_err_inc;
    logic                bit_b;
    logic                bit_p;
    logic                miss;
    logic                chk_bit;
    logic                chk_err;
    logic                err_pulse_q;

    always_comb begin
        bit_b       = din ^ INVERT;
        bit_p       = prbs31_next(hist_q);
        miss        = (bit_b != bit_p);
        win_err_inc = win_err_q + WW'(miss);

        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_bit_d = win_bit_q;
        win_err_d = win_err_q;
        chk_bit   = 1'b0;
        chk_err   = 1'b0;

        if (din_valid) begin
            case (state_q)
                SEARCH: begin
                    hist_d = {hist_q[PRBS_LEN-2:0], bit_b};
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + FW'(1);
                    end else if ((hist_q == '0) || miss) begin
                        // An all-zero history predicts zeros forever, so it must
                        // never accumulate matches.
                        match_d = '0;
                    end else if (match_q == MATCH_TGT - MW'(1)) begin
                        state_d   = LOCKED;
                        match_d   = '0;
                        win_bit_d = '0;
                        win_err_d = '0;
                    end else begin
                        match_d = match_q + MW'(1);
                    end
                end
                LOCKED: begin
                    // Feeding back the prediction keeps one flipped bit from
                    // corrupting the next 31 predictions.
                    hist_d  = {hist_q[PRBS_LEN-2:0], bit_p};
                    chk_bit = 1'b1;
                    chk_err = miss;
                    if ((UNLOCK_ERRS > 0) && miss && (win_err_inc == ERR_TGT)) begin
                        state_d   = SEARCH;
                        fill_d    = '0;
                        match_d   = '0;
                        win_bit_d = '0;
                        win_err_d = '0;
                    end else if (win_bit_q == WIN_LAST) begin
                        win_bit_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_bit_d = win_bit_q + WW'(1);
                        win_err_d = win_err_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= SEARCH;
            hist_q      <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_bit_q   <= '0;
            win_err_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_bit_q   <= win_bit_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= chk_err;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;

    sat_counter #(.WIDTH(COUNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (chk_err),
        .clr   (clr_cnt),
        .count (err_count)
    );

    sat_counter #(.WIDTH(COUNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (chk_bit),
        .clr   (clr_cnt),
        .count (bit_count)
    );

endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: three configurations (defaults, INVERT=1,
// COUNT_W=4 with loss-of-lock disabled) share one stimulus stream and are
// compared every cycle against a queue-style model, plus literal checkpoints.
module tb_prbs31_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, din, din_valid, clr_cnt;
    logic        lk0, lk1, lk2, ep0, ep1, ep2;
    logic [15:0] ec0, bc0, ec1, bc1;
    logic [3:0]  ec2, bc2;

    prbs31_checker dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(lk0), .err_pulse(ep0), .err_count(ec0), .bit_count(bc0)
    );
    prbs31_checker #(.INVERT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(lk1), .err_pulse(ep1), .err_count(ec1), .bit_count(bc1)
    );
    prbs31_checker #(.COUNT_W(4), .UNLOCK_ERRS(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(lk2), .err_pulse(ep2), .err_count(ec2), .bit_count(bc2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Received/predicted bits kept in a ring indexed by age; counters as ints.
    int m_seen[3], m_good[3], m_lk[3], m_wpos[3], m_werr[3];
    int m_errc[3], m_bitc[3], m_pulse[3], m_n[3];
    bit m_hb[3][64];

    function automatic void m_reset();
        for (int k = 0; k < 3; k++) begin
            m_seen[k] = 0; m_good[k] = 0; m_lk[k] = 0; m_wpos[k] = 0; m_werr[k] = 0;
            m_errc[k] = 0; m_bitc[k] = 0; m_pulse[k] = 0; m_n[k] = 0;
            for (int i = 0; i < 64; i++) m_hb[k][i] = 1'b0;
        end
    endfunction

    function automatic bit m_hist(input int k, input int age);
        return m_hb[k][(m_n[k] - age + 64) % 64];
    endfunction

    function automatic void m_push(input int k, input bit v);
        m_hb[k][m_n[k]] = v;
        m_n[k] = (m_n[k] + 1) % 64;
    endfunction

    function automatic void m_step(input int k, input bit d);
        bit b, p, any;
        int cmax, uerr;
        cmax = (k == 2) ? 15 : 65535;
        uerr = (k == 2) ? 0 : 8;
        b = d ^ (k == 1);
        p = m_hist(k, 28) ^ m_hist(k, 31);
        if (m_lk[k] == 0) begin
            if (m_seen[k] < 31) begin
                m_seen[k]++;
            end else begin
                any = 1'b0;
                for (int a = 1; a <= 31; a++) any = any | m_hist(k, a);
                if (!any || (b != p)) m_good[k] = 0;
                else m_good[k]++;
                if (m_good[k] == 64) begin
                    m_lk[k] = 1; m_good[k] = 0; m_wpos[k] = 0; m_werr[k] = 0;
                end
            end
            m_push(k, b);
        end else begin
            m_push(k, p);
            if (m_bitc[k] < cmax) m_bitc[k]++;
            if (b != p) begin
                m_pulse[k] = 1;
                if (m_errc[k] < cmax) m_errc[k]++;
                m_werr[k]++;
            end
            m_wpos[k]++;
            if ((uerr > 0) && (b != p) && (m_werr[k] == uerr)) begin
                m_lk[k] = 0; m_seen[k] = 0; m_good[k] = 0;
            end else if (m_wpos[k] == 64) begin
                m_wpos[k] = 0; m_werr[k] = 0;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            m_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_pulse[k] = 0;
                if (din_valid) m_step(k, din);
                if (clr_cnt) begin
                    m_errc[k] = 0;
                    m_bitc[k] = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en  = 1'b0;
    int pulses0 = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("locked0", lk0, m_lk[0]);   check("pulse0", ep0, m_pulse[0]);
            check("errcnt0", ec0, m_errc[0]); check("bitcnt0", bc0, m_bitc[0]);
            check("locked1", lk1, m_lk[1]);   check("pulse1", ep1, m_pulse[1]);
            check("errcnt1", ec1, m_errc[1]); check("bitcnt1", bc1, m_bitc[1]);
            check("locked2", lk2, m_lk[2]);   check("pulse2", ep2, m_pulse[2]);
            check("errcnt2", ec2, m_errc[2]); check("bitcnt2", bc2, m_bitc[2]);
            if (ep0) pulses0++;
        end
    end

    // ---------------- stimulus ----------------
    bit gs[0:2047];
    bit flip[0:2047];
    int gidx, vcount, first_lock0, first_lock1, clr_at;
    bit gaps, cmpl, zero, ever0, ever1;

    task automatic cyc(input bit d, input bit v, input bit c);
        din = d; din_valid = v; clr_cnt = c;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        gidx = 0; vcount = 0; first_lock0 = -1; first_lock1 = -1; clr_at = -1;
        gaps = 1'b0; cmpl = 1'b0; zero = 1'b0; ever0 = 1'b0; ever1 = 1'b0;
        for (int i = 0; i < 2048; i++) flip[i] = 1'b0;
        chk_en = 1'b1;
    endtask

    // Sends n valid bits; bit numbers are 1-based, flip[] indexed by bit number.
    task automatic stream(input int n);
        bit d, junk;
        int ngap;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                ngap = int'($urandom_range(2, 0));
                for (int g = 0; g < ngap; g++) begin
                    junk = 1'($urandom_range(1, 0));
                    cyc(junk, 1'b0, 1'b0);
                end
            end
            d = zero ? 1'b0 : (gs[gidx] ^ flip[gidx + 1] ^ cmpl);
            cyc(d, 1'b1, (gidx + 1) == clr_at);
            gidx++; vcount++;
            if (first_lock0 < 0 && lk0) first_lock0 = vcount;
            if (first_lock1 < 0 && lk1) first_lock1 = vcount;
            ever0 = ever0 | lk0;
            ever1 = ever1 | lk1;
        end
        din_valid = 1'b0;
    endtask

    initial begin
        int ones;
        rst_n = 1'b1; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;

        // Generator output with seed 1: 30 zeros then a one, then s[t]=s[t-28]^s[t-31].
        for (int t = 0; t < 2048; t++) begin
            if (t < 31) gs[t] = (t == 30);
            else        gs[t] = gs[t - 28] ^ gs[t - 31];
        end
        ones = 0;
        for (int t = 0; t < 58; t++) ones += int'(gs[t]);
        check("gen_ones_0_57", ones, 1);
        check("gen_bit58", gs[58], 1);

        // A: reset state, lock at bit 95, 1000 clean bits.
        do_reset();
        check("rst_locked", lk0, 0); check("rst_pulse", ep0, 0);
        check("rst_errcnt", ec0, 0); check("rst_bitcnt", bc0, 0);
        stream(95);
        check("A_lock_bit", first_lock0, 95);
        stream(1000);
        check("A_errcnt", ec0, 0); check("A_bitcnt", bc0, 1000);

        // B: three isolated flips while locked.
        do_reset();
        flip[200] = 1'b1; flip[400] = 1'b1; flip[600] = 1'b1;
        pulses0 = 0;
        stream(700);
        check("B_pulses", pulses0, 3); check("B_errcnt", ec0, 3);
        check("B_locked", lk0, 1);     check("B_bitcnt", bc0, 605);
        check("B_errcnt_w4", ec2, 3);  check("B_bitcnt_sat", bc2, 15);

        // C: 8 errors inside the window starting at bit 288 -> unlock, relock.
        do_reset();
        for (int i = 300; i <= 307; i++) flip[i] = 1'b1;
        stream(306);
        check("C_locked_pre", lk0, 1);
        stream(1);
        check("C_unlock", lk0, 0); check("C_pulse8", ep0, 1); check("C_errcnt", ec0, 8);
        check("C_nounlock_w4", lk2, 1);
        stream(94);
        check("C_relock_early", lk0, 0);
        stream(1);
        check("C_relock", lk0, 1); check("C_bitcnt", bc0, 212);

        // D: all-zero input never locks (DUT1 sees all ones).
        do_reset();
        zero = 1'b1;
        stream(500);
        check("D_never0", ever0, 0); check("D_never1", ever1, 0);

        // E: complemented stream locks only with INVERT=1.
        do_reset();
        cmpl = 1'b1;
        stream(200);
        check("E_never0", ever0, 0); check("E_lock_inv", first_lock1, 95);

        // F: ~50% valid duty with junk on idle cycles, then reset mid-lock.
        do_reset();
        gaps = 1'b1;
        flip[200] = 1'b1; flip[400] = 1'b1; flip[600] = 1'b1;
        pulses0 = 0;
        stream(700);
        check("F_lock_bit", first_lock0, 95); check("F_pulses", pulses0, 3);
        check("F_errcnt", ec0, 3);
        rst_n = 1'b1;
        cyc(gs[gidx], 1'b1, 1'b0);
        rst_n = 1'b0;
        check("F_rst_locked", lk0, 0); check("F_rst_errcnt", ec0, 0); check("F_rst_bitcnt", bc0, 0);

        // G: 20 errors saturate a 4-bit err_count; clr_cnt on an error cycle.
        do_reset();
        for (int i = 0; i < 20; i++) flip[100 + 5 * i] = 1'b1;
        flip[210] = 1'b1;
        clr_at = 210;
        stream(209);
        check("G_errcnt_sat", ec2, 15);
        stream(1);
        check("G_clr_errcnt", ec2, 0); check("G_clr_pulse", ep2, 1); check("G_locked_w4", lk2, 1);

        cyc(1'b0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Receive-side companion to the team's PRBS31 generator (polynomial x^31 + x^28 + 1; taps 27 and 30 of a 31-bit left-shifting register; serial output is bit 30).
- Accepts the serial bit stream and self-synchronises to it without a seed.
- Once locked, flags and counts every bit error and declares loss of lock when errors become too dense.
- Sits on ui_in/uo_out of a loopback test tile for link bit-error-rate measurement.

Parameters:
- LOCK_CNT, 64: consecutive correct predictions required to enter LOCKED.
- WINDOW, 64: length of the loss-of-lock window, in valid bits.
- UNLOCK_ERRS, 8: errors within one window that force SEARCH; 0 disables loss of lock.
- COUNT_W, 16: width of err_count and bit_count.
- INVERT, 0: 1 means the incoming stream is the bitwise complement of the PRBS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-high (1 = reset), despite the name.
- din  input  1  serial PRBS bit.
- din_valid  input  1  din is sampled only on cycles where this is 1.
- clr_cnt  input  1  synchronous clear of err_count and bit_count.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per detected bit error.
- err_count  output  COUNT_W  saturating count of errors detected while locked.
- bit_count  output  COUNT_W  saturating count of valid bits checked while locked.

Behaviour:
- Reset (rst_n=1 at a rising edge): history=0, fill=0, match=0, window counters=0, state=SEARCH. All outputs 0. Reset mid-operation abandons lock immediately.
- Input bit: b = din ^ INVERT. History h[30:0]: h[0] is the most recent bit. Predicted bit p = h[27] ^ h[30]. All state advances only on din_valid=1; din_valid=0 cycles are fully transparent.
- SEARCH:
  - Shift b into history every valid bit.
  - fill counts 0..31 and saturates at 31. No comparison is made until fill=31.
  - With fill=31 and history != 0: b==p increments match; b!=p clears match to 0.
  - An all-zero history clears match, so an all-zero stream never locks.
  - When match reaches LOCK_CNT, go to LOCKED; locked is high the cycle after that bit is sampled.
- LOCKED:
  - Shift p (not b) into history, so a flipped bit is counted exactly once.
  - Each valid bit increments bit_count.
  - b!=p: err_pulse=1 on the next cycle, and err_count increments.
  - Window: a bit counter wraps every WINDOW valid bits, and the window error count resets at each wrap.
  - If UNLOCK_ERRS>0 and the window error count reaches UNLOCK_ERRS: go to SEARCH on that bit. locked drops the next cycle, fill/match/window are cleared, and history is refilled from received data.
  - The error that triggers unlock is still pulsed and counted.
- Counters:
  - err_count and bit_count saturate at all-ones and do not change in SEARCH.
  - clr_cnt=1 zeroes both and takes priority over a same-cycle increment; err_pulse is still emitted in that case.
  - Counters persist across loss and regain of lock, and are cleared only by clr_cnt or reset.
- Latency: one cycle from the sampled bit to err_pulse and locked.
- Nominal lock time: 31 + LOCK_CNT valid bits (95 at defaults).

Decomposition:
- Shared package prbs31_pkg holds:
  - PRBS_LEN=31, TAP_A=27, TAP_B=30;
  - state typedef {SEARCH, LOCKED};
  - function prbs31_next(h) returning the predicted bit. The generator reuses this function.
- One natural sub-module: sat_counter (width, inc, clr; saturating). It is instantiated for err_count and bit_count.

Test Plan:
- Generator-format stream (seed 1, uninterrupted valid), defaults -> locked rises the cycle after valid bit 95; err_count=0 and bit_count=1000 after 1000 further bits.
- Locked; flip bits 200, 400, 600 -> exactly three err_pulses, err_count=3, locked stays 1.
- Locked; flip 8 bits within one 64-bit window -> locked falls the cycle after the 8th error, err_count=8; clean stream then relocks after 95 more valid bits.
- All-zero din for 500 bits -> locked never asserts. Complemented PRBS with INVERT=0 -> never locks; same stream with INVERT=1 -> locks at bit 95.
- Random din_valid gaps (50% duty) -> lock point and error counts identical in valid-bit terms. rst_n pulse mid-lock -> locked=0 and counts=0 next cycle.
- COUNT_W=4, UNLOCK_ERRS=0; inject 20 errors -> err_count saturates at 15. clr_cnt asserted on an error cycle -> err_count=0 with err_pulse=1.
